cyber_player: RTL and testbench
===============================

CYBER_PLAYER -- requirements
Module: cyber_player

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: number of cycles `press` stays high per emulated key press (legal range 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: minimum number of cycles `press` stays low after each press before another may start (legal range 1..15).
REQ-003 SHALL have port CLOCK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  allows new presses to start when high.
REQ-006 SHALL have port SW  input  9  difficulty threshold, unsigned; a larger value gives more frequent presses.
REQ-007 SHALL have port press  output  1  emulated key level, active-high; drives a player key input directly.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port press_count  output  8  count of presses started since reset.
REQ-010 SHALL have port lfsr  output  10  current LFSR state, exposed for debug and verification.

Function
REQ-011 SHALL hold a 10-bit LFSR that advances every cycle while not in reset: next = {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])}.
REQ-012 The LFSR SHALL have period 1023 starting from 0; the all-ones lock-up state SHALL be unreachable from reset.
REQ-013 SHALL implement a Moore FSM with states IDLE, PRESS and GAP; `press` SHALL be registered, high only in PRESS.
REQ-014 IDLE -> PRESS SHALL occur when enable=1 and {1'b0,SW} > lfsr (unsigned 10-bit compare on the current-cycle values); otherwise the FSM SHALL stay in IDLE.
REQ-015 Latency: a trigger condition true in cycle N SHALL make press=1 starting in cycle N+1.
REQ-016 PRESS SHALL last exactly HOLD_CYCLES cycles, then go to GAP; GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE.
REQ-017 A single cycle-down counter (4 bits) SHALL time both PRESS and GAP; it SHALL load on each state entry.
REQ-018 Deasserting enable during PRESS or GAP SHALL NOT truncate either phase; only new triggers are gated.
REQ-019 SW changes during PRESS or GAP SHALL have no effect until the FSM is back in IDLE.
REQ-020 SW=0 SHALL never trigger; SW=511 SHALL trigger for all LFSR values below 511.
REQ-021 press_count SHALL increment by 1 on every IDLE -> PRESS transition and SHALL wrap from 255 to 0.
REQ-022 Back-to-back presses SHALL be separated by at least GAP_CYCLES low cycles, so each press yields exactly one falling edge at the consumer.
REQ-023 busy SHALL be registered and SHALL equal (state != IDLE).

Reset
REQ-024 While Reset=1 at a rising edge: state=IDLE, lfsr=10'h000, counter=0, press=0, busy=0, press_count=0.
REQ-025 Reset SHALL take priority over every other input, including mid-PRESS and mid-GAP; the next cycle SHALL show reset values.
REQ-026 On the first edge after Reset falls, the LFSR SHALL advance from 0 and trigger evaluation SHALL use lfsr=0.

Verification
REQ-027 Hold Reset for 3 cycles with enable=1, SW=511 -> press=0, busy=0, lfsr=0, press_count=0 throughout.
REQ-028 Release reset with enable=0 -> lfsr sequence 0x000, 0x001, 0x003, 0x007, 0x00F, 0x01F; 0x000 recurs after exactly 1023 cycles; lfsr never equals 0x3FF.
REQ-029 SW=0, enable=1 for 2100 cycles -> press never high, press_count stays 0.
REQ-030 SW=511, enable=1, default parameters, starting from reset release -> press high in cycles 1-2 and low in cycles 3-4; press_count=1 after the first press; no low gap shorter than 2 cycles over 1000 cycles.
REQ-031 enable dropped in the first PRESS cycle -> press still high for exactly 2 cycles, then GAP and IDLE, with no further presses while enable=0; Reset asserted mid-PRESS -> press=0, busy=0, lfsr=0 on the next cycle.
REQ-032 Force 256 presses (SW=511, enable=1) -> press_count reads 255, then 0.

Source files
------------

// File: rtl/cyber_player.sv
`default_nettype none
// ============================================================================
// Module   : cyber_player
// Purpose  : Emulates a player pressing a key. A free-running 10-bit LFSR
//            is compared against a difficulty threshold SW. When triggered,
//            the key is held for HOLD_CYCLES cycles and then released for
//            GAP_CYCLES cycles before the next press can start.
// Ports    : CLOCK       - system clock, rising edge
//            Reset       - synchronous active-high reset
//            enable      - allows new presses to start
//            SW[8:0]     - difficulty threshold; larger means more presses
//            press       - emulated key level (registered, high in PRESS)
//            busy        - high whenever the FSM is not in IDLE (registered)
//            press_count - number of presses started since reset (wraps)
//            lfsr[9:0]   - current LFSR state
// Revision : 1.0 - initial release
// ============================================================================
module cyber_player #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       enable,
  input  logic [8:0] SW,
  output logic       press,
  output logic       busy,
  output logic [7:0] press_count,
  output logic [9:0] lfsr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Phase lengths are loaded as (length - 1) so the phase ends on the
  // cycle in which the counter reads zero.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;
  logic       press_q;
  logic       busy_q;
  logic [7:0] count_q;
  logic       trig;

  // XNOR feedback: all-zero is a legal state, all-ones is the lock-up state
  // and lies outside the 1023-state cycle reached from zero.
  assign lfsr_d = {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};

  // Only evaluated in IDLE, so SW/enable changes mid-press are ignored.
  assign trig = enable && ({1'b0, SW} > lfsr_q);

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lfsr_q  <= 10'h000;
      press_q <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= PRESS;
            cnt_q   <= HOLD_LOAD;
            press_q <= 1'b1;
            busy_q  <= 1'b1;
            count_q <= count_q + 8'd1;
          end
        end
        PRESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= GAP;
            cnt_q   <= GAP_LOAD;
            press_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        GAP: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          press_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign press       = press_q;
  assign busy        = busy_q;
  assign press_count = count_q;
  assign lfsr        = lfsr_q;

endmodule
`default_nettype wire

// File: tb/tb_cyber_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_cyber_player
// Purpose  : Self-checking bench for cyber_player (default parameters).
//            Table of per-cycle vectors plus long-run sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cyber_player;

  logic       clk;
  logic       rst;
  logic       en;
  logic [8:0] sw;
  logic       press;
  logic       busy;
  logic [7:0] press_count;
  logic [9:0] lfsr;

  int total = 0;
  int bad   = 0;

  cyber_player #(.HOLD_CYCLES(2), .GAP_CYCLES(2)) dut (
    .CLOCK       (clk),
    .Reset       (rst),
    .enable      (en),
    .SW          (sw),
    .press       (press),
    .busy        (busy),
    .press_count (press_count),
    .lfsr        (lfsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [8:0] sw;
    logic       press;
    logic       busy;
    logic [7:0] cnt;
    logic [9:0] lfsr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic [8:0] s);
    rst = r; en = e; sw = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  task automatic add(input logic r, input logic e, input logic [8:0] s,
                     input logic p, input logic b, input logic [7:0] c,
                     input logic [9:0] l);
    vec_t v;
    v.rst = r; v.en = e; v.sw = s; v.press = p; v.busy = b; v.cnt = c; v.lfsr = l;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sw = 9'd511;

    // ---- reset held with enable=1, SW=511
    add(1, 1, 511, 0, 0, 0, 10'h000);
    add(1, 1, 511, 0, 0, 0, 10'h000);
    add(1, 1, 511, 0, 0, 0, 10'h000);
    // ---- first press from reset release; SW=0 mid-press has no effect
    add(0, 1, 511, 1, 1, 1, 10'h001);
    add(0, 1,   0, 1, 1, 1, 10'h003);
    add(0, 1,   0, 0, 1, 1, 10'h007);
    add(0, 1,   0, 0, 1, 1, 10'h00F);
    add(0, 1, 511, 0, 0, 1, 10'h01F);
    add(0, 1, 511, 1, 1, 2, 10'h03F);
    // ---- enable dropped in first PRESS cycle
    add(1, 1, 511, 0, 0, 0, 10'h000);
    add(0, 1, 511, 1, 1, 1, 10'h001);
    add(0, 0, 511, 1, 1, 1, 10'h003);
    add(0, 0, 511, 0, 1, 1, 10'h007);
    add(0, 0, 511, 0, 1, 1, 10'h00F);
    add(0, 0, 511, 0, 0, 1, 10'h01F);
    add(0, 0, 511, 0, 0, 1, 10'h03F);
    // ---- new press, then reset mid-PRESS
    add(0, 1, 511, 1, 1, 2, 10'h07F);
    add(1, 1, 511, 0, 0, 0, 10'h000);
    // ---- threshold boundaries: 0>0 no, 1>1 no, 4>3 yes
    add(0, 1,   0, 0, 0, 0, 10'h001);
    add(0, 1,   1, 0, 0, 0, 10'h003);
    add(0, 1,   4, 1, 1, 1, 10'h007);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].sw);
      chk($sformatf("vec%0d.press", i), 32'(press),       32'(vecs[i].press));
      chk($sformatf("vec%0d.busy",  i), 32'(busy),        32'(vecs[i].busy));
      chk($sformatf("vec%0d.count", i), 32'(press_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d.lfsr",  i), 32'(lfsr),        32'(vecs[i].lfsr));
    end

    // ---- LFSR period and lock-up state, enable=0
    begin
      logic [9:0] model;
      int first_zero;
      int seen_ones;
      int lfsr_bad;
      step(1, 0, 0);
      model = 10'h000;
      first_zero = -1; seen_ones = 0; lfsr_bad = 0;
      for (int c = 1; c <= 1100; c++) begin
        step(0, 0, 0);
        model = lfsr_next(model);
        if (lfsr !== model) lfsr_bad++;
        if (lfsr == 10'h3FF) seen_ones++;
        if (lfsr == 10'h000 && first_zero < 0) first_zero = c;
      end
      chk("lfsr_model", 32'(lfsr_bad), 32'd0);
      chk("lfsr_period", 32'(first_zero), 32'd1023);
      chk("lfsr_no_lockup", 32'(seen_ones), 32'd0);
      chk("lfsr_idle_count", 32'(press_count), 32'd0);
    end

    // ---- SW=0 never triggers
    begin
      int hi = 0;
      step(1, 1, 0);
      for (int c = 0; c < 2100; c++) begin
        step(0, 1, 0);
        if (press) hi++;
      end
      chk("sw0_press", 32'(hi), 32'd0);
      chk("sw0_count", 32'(press_count), 32'd0);
    end

    // ---- SW=511: hold exactly 2, low gap at least 2, over 1000 cycles
    begin
      int hi_run = 0;
      int lo_run = 100;
      int short_gap = 0;
      int wrong_hold = 0;
      int presses = 0;
      logic prev = 1'b0;
      step(1, 1, 511);
      for (int c = 0; c < 1000; c++) begin
        step(0, 1, 511);
        if (press && !prev) begin
          presses++;
          if (lo_run < 2) short_gap++;
          hi_run = 1;
        end else if (press) begin
          hi_run++;
        end else if (prev) begin
          if (hi_run != 2) wrong_hold++;
          lo_run = 1;
        end else begin
          lo_run++;
        end
        prev = press;
      end
      chk("gap_min", 32'(short_gap), 32'd0);
      chk("hold_len", 32'(wrong_hold), 32'd0);
      chk("press_counted", 32'(press_count), 32'(presses & 8'hFF));
    end

    // ---- press_count wraps 255 -> 0
    begin
      int budget;
      step(1, 1, 511);
      budget = 0;
      while (press_count != 8'd255 && budget < 20000) begin
        step(0, 1, 511);
        budget++;
      end
      chk("count_reach_255", 32'(press_count), 32'd255);
      budget = 0;
      while (press_count == 8'd255 && budget < 200) begin
        step(0, 1, 511);
        budget++;
      end
      chk("count_wrap_0", 32'(press_count), 32'd0);
      chk("count_wrap_press", 32'(press), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
